// File: rtl/uart_tx_cfg_if.sv
// UART transmitter host-side bundle.
// Write handshake plus line and status outputs.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

  logic                 i_valid;
  logic [DATA_BITS-1:0] i_data;
  logic                 o_ready;
  logic                 o_tx;
  logic                 o_busy;
  logic                 o_tx_done;
  logic [CNTW-1:0]      o_fifo_count;

  modport master (
    output i_valid, i_data,
    input  o_ready, o_tx, o_busy,
    input  o_tx_done, o_fifo_count
  );

  modport slave (
    input  i_valid, i_data,
    output o_ready, o_tx, o_busy,
    output o_tx_done, o_fifo_count
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter.
// Small FIFO feeding a frame FSM; line is registered.
module uart_tx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic           i_clk,
  input logic           i_reset_n,
  uart_tx_cfg_if.slave  bus
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(OVERSAMPLE);
  localparam int BW   = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP
  } state_t;

  state_t state, state_n;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CNTW-1:0]      count;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par_q, par_n;
  logic                 tx, tx_n;
  logic                 done, done_n;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;

  logic bit_end, last_data, last_stop;
  logic has_word;

  assign head      = mem[rd_ptr];
  assign has_word  = (count != '0);
  assign push      = bus.i_valid && bus.o_ready;
  assign bit_end   = (cnt == CW'(OVERSAMPLE - 1));
  assign last_data = (bit_idx == BW'(DATA_BITS - 1));
  assign last_stop = (STOP_BITS == 1) || stop_idx;

  assign bus.o_ready      = (count != CNTW'(FIFO_DEPTH));
  assign bus.o_fifo_count = count;
  assign bus.o_tx         = tx;
  assign bus.o_busy       = (state != IDLE);
  assign bus.o_tx_done    = done;

  // FIFO storage; contents need no reset
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= bus.i_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Next state, pop, shifter and line value
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    shift_n = shift;
    par_n   = par_q;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (has_word) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_n = shift >> 1;
          if (last_data)
            state_n = (PARITY != 0) ? PAR : STOP;
        end
      end
      PAR: begin
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        if (bit_end && last_stop) begin
          done_n  = 1'b1;
          state_n = IDLE;
          if (has_word) begin
            pop     = 1'b1;
            state_n = START;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (pop) begin
      shift_n = head;
      par_n   = (PARITY == 1) ? ~^head : ^head;
    end
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PAR:     tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  // FSM state, line register and bit timing
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      shift    <= '0;
      par_q    <= 1'b0;
      tx       <= 1'b1;
      done     <= 1'b0;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else begin
      state <= state_n;
      shift <= shift_n;
      par_q <= par_n;
      tx    <= tx_n;
      done  <= done_n;
      if (state_n != state || bit_end)
        cnt <= '0;
      else if (state != IDLE)
        cnt <= cnt + 1'b1;
      if (state_n != state)
        bit_idx <= '0;
      else if (state == DATA && bit_end)
        bit_idx <= bit_idx + 1'b1;
      if (state_n != state)
        stop_idx <= 1'b0;
      else if (state == STOP && bit_end)
        stop_idx <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg.
// Four configurations share clock and reset.
module tb_uart_tx_cfg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_cfg_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) b0();
  uart_tx_cfg_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) b1();
  uart_tx_cfg_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) b2();
  uart_tx_cfg_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) b3();

  uart_tx_cfg u0 (.i_clk(clk), .i_reset_n(rst_n), .bus(b0.slave));
  uart_tx_cfg #(.PARITY(2)) u1 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(b1.slave));
  uart_tx_cfg #(.PARITY(1)) u2 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(b2.slave));
  uart_tx_cfg #(.DATA_BITS(7), .OVERSAMPLE(4), .STOP_BITS(2)) u3 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(b3.slave));

  int total = 0;
  int bad = 0;
  int sel = 0;
  logic tx_mon, done_mon, rdy_mon;

  always_comb begin
    case (sel)
      1: begin tx_mon = b1.o_tx; done_mon = b1.o_tx_done; rdy_mon = b1.o_ready; end
      2: begin tx_mon = b2.o_tx; done_mon = b2.o_tx_done; rdy_mon = b2.o_ready; end
      3: begin tx_mon = b3.o_tx; done_mon = b3.o_tx_done; rdy_mon = b3.o_ready; end
      default: begin tx_mon = b0.o_tx; done_mon = b0.o_tx_done; rdy_mon = b0.o_ready; end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Passive receiver and activity counters on the default instance
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] rx_sh;
  int rx_pos = 0;
  bit rx_on = 0;
  int busy_clks = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (b0.o_busy) busy_clks++;
    if (b0.o_tx_done) done_cnt++;
    if (!rst_n) begin
      rx_on = 0;
      rx_q.delete();
    end else if (!rx_on) begin
      if (b0.o_tx == 1'b0) begin
        rx_on = 1;
        rx_pos = 0;
      end
    end else begin
      rx_pos++;
      if (rx_pos >= 24 && rx_pos <= 136 && (rx_pos % 16) == 8)
        rx_sh[(rx_pos - 24) / 16] = b0.o_tx;
      if (rx_pos == 159) begin
        rx_q.push_back(rx_sh);
        rx_on = 0;
      end
    end
  end

  task automatic drive(input int s, input logic v, input logic [8:0] d);
    case (s)
      1: begin b1.i_valid = v; b1.i_data = d[7:0]; end
      2: begin b2.i_valid = v; b2.i_data = d[7:0]; end
      3: begin b3.i_valid = v; b3.i_data = d[6:0]; end
      default: begin b0.i_valid = v; b0.i_data = d[7:0]; end
    endcase
  endtask

  // Single write; returns at the negedge after the accepting edge
  task automatic wr(input int s, input logic [8:0] d);
    sel = s;
    @(negedge clk);
    chk("wr_ready", rdy_mon, 1'b1);
    drive(s, 1'b1, d);
    if (s == 0) exp_q.push_back(d[7:0]);
    @(posedge clk);
    @(negedge clk);
    drive(s, 1'b0, 9'h1AA);
  endtask

  task automatic frame_chk(input string tag, input logic [15:0] exp,
                           input int nb, input int os);
    int ok;
    int dn;
    dn = 0;
    for (int b = 0; b < nb; b++) begin
      ok = 0;
      for (int c = 0; c < os; c++) begin
        @(negedge clk);
        if (tx_mon === exp[b]) ok++;
        if (done_mon) dn++;
      end
      chk($sformatf("%s_bit%0d", tag, b), ok, os);
    end
    chk({tag, "_done_early"}, dn, 0);
    @(negedge clk);
    chk({tag, "_done"}, done_mon, 1'b1);
    @(negedge clk);
    chk({tag, "_done_once"}, done_mon, 1'b0);
  endtask

  task automatic score(input string tag);
    chk({tag, "_nwords"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (b0.o_busy && t < 3000);
    chk({tag, "_idle"}, b0.o_busy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  logic [7:0] w [8];
  int n;
  bit dropped;
  int hi;

  initial begin
    w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    drive(0, 1'b0, 9'h0);
    drive(1, 1'b0, 9'h0);
    drive(2, 1'b0, 9'h0);
    drive(3, 1'b0, 9'h0);
    repeat (3) @(negedge clk);
    chk("rst_tx", b0.o_tx, 1'b1);
    chk("rst_busy", b0.o_busy, 1'b0);
    chk("rst_done", b0.o_tx_done, 1'b0);
    chk("rst_count", b0.o_fifo_count, 0);
    chk("rst_ready", b0.o_ready, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5, 8N1: 0,1,0,1,0,0,1,0,1,1
    wr(0, 9'h0A5);
    frame_chk("a5", 16'b11_0100_1010, 10, 16);
    score("a5");

    // 0x07 even parity -> parity 1
    wr(1, 9'h007);
    frame_chk("even", 16'b110_0000_1110, 11, 16);
    // 0x07 odd parity -> parity 0
    wr(2, 9'h007);
    frame_chk("odd", 16'b100_0000_1110, 11, 16);
    // 0x41, 7 data bits, 2 stop, 4x: 0,1,0,0,0,0,0,1,1,1
    wr(3, 9'h041);
    frame_chk("s7", 16'b11_1000_0010, 10, 4);
    sel = 0;

    // Burst with valid held: five accepted, five frames back to back
    @(negedge clk);
    busy_clks = 0;
    done_cnt = 0;
    n = 0;
    dropped = 0;
    b0.i_valid = 1'b1;
    b0.i_data = w[0];
    for (int c = 0; c < 12 && !dropped; c++) begin
      if (!b0.o_ready) begin
        dropped = 1;
      end else begin
        @(posedge clk);
        exp_q.push_back(w[n]);
        n++;
        @(negedge clk);
        b0.i_data = w[n % 8];
      end
    end
    b0.i_valid = 1'b0;
    chk("burst_acc", n, 5);
    chk("burst_full", b0.o_fifo_count, 4);
    drain("burst");
    chk("burst_busy_clks", busy_clks, 800);
    chk("burst_dones", done_cnt, 5);
    score("burst");

    // Push and pop on one edge at count 1 and count 2
    @(negedge clk);
    b0.i_valid = 1'b1;
    b0.i_data = 8'h3C;
    exp_q.push_back(8'h3C);
    @(posedge clk);
    @(negedge clk);
    b0.i_data = 8'hC3;
    exp_q.push_back(8'hC3);
    @(posedge clk);
    @(negedge clk);
    chk("pp_cnt1", b0.o_fifo_count, 1);
    b0.i_data = 8'h5A;
    exp_q.push_back(8'h5A);
    @(posedge clk);
    @(negedge clk);
    b0.i_valid = 1'b0;
    chk("pp_pre_cnt", b0.o_fifo_count, 2);
    repeat (158) @(negedge clk);
    chk("pp_ready", b0.o_ready, 1'b1);
    b0.i_valid = 1'b1;
    b0.i_data = 8'h96;
    exp_q.push_back(8'h96);
    @(negedge clk);
    b0.i_valid = 1'b0;
    chk("pp_cnt2", b0.o_fifo_count, 2);
    chk("pp_done", b0.o_tx_done, 1'b1);
    b0.i_data = 8'hFF;
    drain("pp");
    score("pp");

    // Reset in the data bits of frame 2 with three words queued
    @(negedge clk);
    b0.i_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b0.i_data = (i == 0) ? 8'hF0 : ((i == 1) ? 8'h00 : 8'(i));
      @(posedge clk);
      @(negedge clk);
    end
    b0.i_valid = 1'b0;
    chk("rq_cnt4", b0.o_fifo_count, 4);
    repeat (176) @(negedge clk);
    chk("rq_cnt3", b0.o_fifo_count, 3);
    chk("rq_pre_tx", b0.o_tx, 1'b0);
    done_cnt = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rq_tx", b0.o_tx, 1'b1);
    chk("rq_count", b0.o_fifo_count, 0);
    chk("rq_busy", b0.o_busy, 1'b0);
    chk("rq_ready", b0.o_ready, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    hi = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (b0.o_tx === 1'b1) hi++;
    end
    chk("rq_idle_tx", hi, 40);
    chk("rq_no_done", done_cnt, 0);
    chk("rq_busy_after", b0.o_busy, 1'b0);
    exp_q.delete();
    rx_q.delete();
    wr(0, 9'h0A5);
    frame_chk("rq_a5", 16'b11_0100_1010, 10, 16);
    score("rq");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter DATA_BITS, default 8, meaning data bits per frame; the legal range SHALL be 5..9.
REQ-002 Parameter OVERSAMPLE, default 16, meaning clocks per bit period; the legal range SHALL be 4..256.
REQ-003 Parameter PARITY, default 0, meaning parity mode; the encoding SHALL be 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1, meaning stop bits per frame; the legal values SHALL be 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries; the value SHALL be a power of 2, at least 2.
REQ-006 Port i_clk, input, width 1, meaning the single clock; the block SHALL use one clock and all flops SHALL be posedge i_clk.
REQ-007 Port i_reset_n, input, width 1, meaning reset; reset SHALL be asynchronous and active-low.
REQ-008 Port i_valid, input, width 1, meaning a write request for i_data.
REQ-009 Port i_data, input, width DATA_BITS, meaning the word to send.
REQ-010 Port o_ready, output, width 1, meaning the FIFO is not full; a write SHALL be accepted on an edge where i_valid and o_ready are both 1.
REQ-011 Port o_tx, output, width 1, meaning the serial line; it SHALL be registered and idle high.
REQ-012 Port o_busy, output, width 1, meaning the FSM is not in IDLE.
REQ-013 Port o_tx_done, output, width 1, meaning a one-clock pulse at frame end.
REQ-014 Port o_fifo_count, output, width clog2(FIFO_DEPTH)+1, meaning stored words.

Function
REQ-015 Frame: start 0, DATA_BITS bits LSB first, optional parity bit, STOP_BITS stop 1s; each bit SHALL last exactly OVERSAMPLE clocks.
REQ-016 Parity bit: even = XOR of data bits; odd = inverted XOR; no parity state when PARITY=0.
REQ-017 FSM states: IDLE, START, DATA, PAR, STOP; the transition sequence SHALL be IDLE->START->DATA->(PAR)->STOP->IDLE, or STOP->START as in REQ-020.
REQ-018 IDLE with FIFO non-empty: pop the head on that edge, load the shifter, enter START, and drive o_tx to 0.
REQ-019 Latency: for a word accepted on edge k into an empty FIFO with the FSM idle, o_tx SHALL go low after edge k+1.
REQ-020 Back-to-back: if the FIFO is non-empty at the last clock of the last stop bit, the FSM SHALL go directly to START with zero idle clocks between frames.
REQ-021 o_tx_done SHALL be 1 for exactly the one clock following the last clock of the last stop bit; it SHALL pulse once per frame, including during back-to-back frames.
REQ-022 FIFO full: o_ready=0 and writes ignored; o_fifo_count SHALL never exceed FIFO_DEPTH.
REQ-023 Simultaneous push and pop: both SHALL occur and o_fifo_count SHALL be unchanged; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 i_data SHALL be captured at acceptance; later changes to i_data SHALL NOT affect queued or in-flight frames.
REQ-025 The bit-period counter SHALL be clog2(OVERSAMPLE) bits wide, count 0..OVERSAMPLE-1, and clear on every state change.
REQ-026 o_busy SHALL be 1 in every state except IDLE.

Reset
REQ-027 While i_reset_n=0: o_tx=1, o_busy=0, o_tx_done=0, o_fifo_count=0, o_ready=1, FSM=IDLE, pointers and counters 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously), discard all FIFO contents, and produce no o_tx_done pulse.
REQ-029 After reset release, the first accepted word SHALL follow REQ-019 timing.

Verification
REQ-030 Defaults, write 0xA5 -> o_tx = 0,1,0,1,0,0,1,0,1,1 at 16 clocks per bit, 160 clocks total, o_tx_done pulses once after clock 160.
REQ-031 PARITY=2, write 0x07 -> parity bit 1; PARITY=1, write 0x07 -> parity bit 0; frame 176 clocks.
REQ-032 DATA_BITS=7, STOP_BITS=2, OVERSAMPLE=4, write 0x41 -> frame 0,1,0,0,0,0,0,1,1,1 lasting 40 clocks.
REQ-033 FIFO_DEPTH=4, hold i_valid=1 with 8 distinct words from idle -> exactly 5 accepted before o_ready drops; 5 frames sent back-to-back with no idle gap; 5 o_tx_done pulses.
REQ-034 Assert i_reset_n=0 during the DATA state of frame 2 with 3 words queued -> o_tx=1 at once, o_fifo_count=0, no o_tx_done; after release o_tx stays 1 until a new write.
REQ-035 Push and pop on the same edge at count 2 -> count stays 2; checker compares the serialized byte stream against the accepted-word queue in order.
